// File: rtl/downsample_window_ctrl.sv
// downsample_window_ctrl
// Front-end sequencer for the 2x2 fp16 downsampler convolution stage.
// Takes a raster pixel stream, buffers one (even) input line and forms
// 2x2 windows at stride 2 on the following (odd) line. Emits one window per
// odd/odd input coordinate, one cycle after the completing pixel is accepted.
//
// Optional build macro: DOWNSAMPLE_WINDOW_CTRL_ERR_EN
//   Adds a sticky err_o flag that records frame aborts (sof_i mid-frame)
//   and valid pixels dropped while idle. Cleared only by reset.
module downsample_window_ctrl #(
  parameter int EXP_WIDTH    = 5,
  parameter int FRAC_WIDTH   = 10,
  parameter int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter logic [FP_WIDTH_REG-1:0] KERNEL_COEFF = 16'h3400
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [FP_WIDTH_REG-1:0]              pixel_i,
  input  logic                                 valid_i,
  input  logic                                 sof_i,
  output logic [1:0][1:0][FP_WIDTH_REG-1:0]    window_o,
  output logic [1:0][1:0][FP_WIDTH_REG-1:0]    kernel_o,
  output logic [15:0]                          col_o,
  output logic [15:0]                          row_o,
  output logic                                 valid_o,
  output logic                                 frame_done_o,
  output logic                                 busy_o
`ifdef DOWNSAMPLE_WINDOW_CTRL_ERR_EN
  ,
  output logic                                 err_o
`endif
);

  // Line-buffer address width (column index within one input line).
  localparam int AW = $clog2(IMAGE_WIDTH);

  // Frame geometry limits, pre-sized to the 16-bit counters.
  localparam logic [15:0] LAST_COL  = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] LAST_ROW  = 16'(IMAGE_HEIGHT - 1);
  localparam logic [15:0] PEN_ROW   = 16'(IMAGE_HEIGHT - 2);
  localparam logic [15:0] LAST_OCOL = 16'(IMAGE_WIDTH / 2 - 1);
  localparam logic [15:0] LAST_OROW = 16'(IMAGE_HEIGHT / 2 - 1);
  localparam bit          H_ODD     = (IMAGE_HEIGHT % 2) == 1;

  // Sequencer states.
  localparam logic [1:0] S_IDLE  = 2'd0;  // waiting for sof_i
  localparam logic [1:0] S_EVEN  = 2'd1;  // filling the line buffer
  localparam logic [1:0] S_ODD   = 2'd2;  // forming windows
  localparam logic [1:0] S_DRAIN = 2'd3;  // swallowing the unpaired last line

  // Registered state.
  logic [1:0]              r_state;
  logic [15:0]             r_col;
  logic [15:0]             r_row;
  logic [FP_WIDTH_REG-1:0] r_left;
  logic [FP_WIDTH_REG-1:0] r_linebuf [IMAGE_WIDTH];

  // Registered outputs.
  logic [1:0][1:0][FP_WIDTH_REG-1:0] r_window;
  logic [15:0]             r_col_o;
  logic [15:0]             r_row_o;
  logic                    r_valid_o;
  logic                    r_frame_done_o;

  // Next-state / control decode.
  logic [1:0]              w_state_nxt;
  logic [15:0]             w_col_nxt;
  logic [15:0]             w_row_nxt;
  logic                    w_eol;
  logic                    w_wr_en;
  logic [AW-1:0]           w_wr_addr;
  logic                    w_left_en;
  logic                    w_emit;
  logic                    w_frame_done;
  logic                    w_abort;
  logic                    w_drop;

  // Line-buffer read ports for the upper half of the window.
  logic [AW-1:0]           w_rd_addr;
  logic [AW-1:0]           w_rd_addr_prev;
  logic [FP_WIDTH_REG-1:0] w_up_right;
  logic [FP_WIDTH_REG-1:0] w_up_left;

  assign w_eol          = (r_col == LAST_COL);
  assign w_rd_addr      = r_col[AW-1:0];
  assign w_rd_addr_prev = w_rd_addr - AW'(1);
  assign w_up_right     = r_linebuf[w_rd_addr];
  assign w_up_left      = r_linebuf[w_rd_addr_prev];

  // Decode the accepted pixel: where it goes, what the counters become,
  // whether it completes a window.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_wr_en     = 1'b0;
    w_wr_addr   = w_rd_addr;
    w_left_en   = 1'b0;
    w_emit      = 1'b0;
    w_abort     = 1'b0;
    w_drop      = 1'b0;

    if (valid_i) begin
      if (sof_i) begin
        // Start (or restart) a frame: this pixel is (0,0).
        w_abort     = (r_state != S_IDLE);
        w_state_nxt = S_EVEN;
        w_col_nxt   = 16'd1;
        w_row_nxt   = 16'd0;
        w_wr_en     = 1'b1;
        w_wr_addr   = '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            w_drop = 1'b1;
          end

          S_EVEN: begin
            w_wr_en = 1'b1;
            if (w_eol) begin
              w_col_nxt   = 16'd0;
              w_row_nxt   = r_row + 16'd1;
              w_state_nxt = S_ODD;
            end else begin
              w_col_nxt = r_col + 16'd1;
            end
          end

          S_ODD: begin
            // Even columns are the left half of a window, odd columns
            // complete it. A trailing even column (odd width) is never paired.
            w_left_en = ~r_col[0];
            w_emit    = r_col[0];
            if (w_eol) begin
              w_col_nxt = 16'd0;
              if (r_row == LAST_ROW) begin
                w_row_nxt   = 16'd0;
                w_state_nxt = S_IDLE;
              end else if (H_ODD && (r_row == PEN_ROW)) begin
                w_row_nxt   = r_row + 16'd1;
                w_state_nxt = S_DRAIN;
              end else begin
                w_row_nxt   = r_row + 16'd1;
                w_state_nxt = S_EVEN;
              end
            end else begin
              w_col_nxt = r_col + 16'd1;
            end
          end

          S_DRAIN: begin
            if (w_eol) begin
              w_col_nxt   = 16'd0;
              w_row_nxt   = 16'd0;
              w_state_nxt = S_IDLE;
            end else begin
              w_col_nxt = r_col + 16'd1;
            end
          end

          default: begin
            w_col_nxt   = 16'd0;
            w_row_nxt   = 16'd0;
            w_state_nxt = S_IDLE;
          end
        endcase
      end
    end
  end

  // The last window of the frame sits at the last output column and row.
  assign w_frame_done = w_emit
                     && ((r_col >> 1) == LAST_OCOL)
                     && ((r_row >> 1) == LAST_OROW);

  // FSM state and position counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: sequential state is assigned with <= so every register
      // samples the pre-edge values, independent of statement order.
      r_state <= S_IDLE;
      r_col   <= 16'd0;
      r_row   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // Lower-left pixel of the window being formed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_left <= '0;
    end else if (w_left_en) begin
      r_left <= pixel_i;
    end
  end

  // One-line buffer holding the even input row.
  // NOTE: the line buffer has no reset; its contents are always rewritten
  // before being read, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_linebuf[w_wr_addr] <= pixel_i;
    end
  end

  // Registered window, position and strobes for the convolution stage.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_window       <= '0;
      r_col_o        <= 16'd0;
      r_row_o        <= 16'd0;
      r_valid_o      <= 1'b0;
      r_frame_done_o <= 1'b0;
    end else begin
      r_valid_o      <= w_emit;
      r_frame_done_o <= w_frame_done;
      if (w_emit) begin
        r_window[0][0] <= w_up_left;
        r_window[0][1] <= w_up_right;
        r_window[1][0] <= r_left;
        r_window[1][1] <= pixel_i;
        r_col_o        <= r_col >> 1;
        r_row_o        <= r_row >> 1;
      end
    end
  end

`ifdef DOWNSAMPLE_WINDOW_CTRL_ERR_EN
  logic r_err;

  // Sticky protocol-error flag: mid-frame restart or pixel dropped in idle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
    end else if (w_abort || w_drop) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

  assign window_o     = r_window;
  assign kernel_o     = {4{KERNEL_COEFF}};
  assign col_o        = r_col_o;
  assign row_o        = r_row_o;
  assign valid_o      = r_valid_o;
  assign frame_done_o = r_frame_done_o;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_downsample_window_ctrl.sv
// tb_downsample_window_ctrl
// Scoreboard bench: stimulus pushes the expected window for every completing
// pixel; per-instance monitors pop and compare whenever valid_o is seen.
// Two instances: 4x4 and 5x5 frames. Pixel tag = row*16 + col.
module tb_downsample_window_ctrl;

  typedef logic [1:0][1:0][15:0] win_t;

  typedef struct {
    win_t        win;
    logic [15:0] col;
    logic [15:0] row;
    logic        done;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [15:0] pixel = '0;
  logic        sof = 1'b0;
  logic        v4 = 1'b0;
  logic        v5 = 1'b0;

  win_t        win4, ker4, win5, ker5;
  logic [15:0] col4, row4, col5, row5;
  logic        vo4, fd4, busy4, vo5, fd5, busy5;
`ifdef DOWNSAMPLE_WINDOW_CTRL_ERR_EN
  logic        err4, err5;
`endif

  exp_t q4[$];
  exp_t q5[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  downsample_window_ctrl #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .pixel_i(pixel), .valid_i(v4), .sof_i(sof),
    .window_o(win4), .kernel_o(ker4), .col_o(col4), .row_o(row4),
    .valid_o(vo4), .frame_done_o(fd4), .busy_o(busy4)
`ifdef DOWNSAMPLE_WINDOW_CTRL_ERR_EN
    , .err_o(err4)
`endif
  );

  downsample_window_ctrl #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(5)) u_dut5 (
    .clk_i(clk), .rst_i(rst_i), .pixel_i(pixel), .valid_i(v5), .sof_i(sof),
    .window_o(win5), .kernel_o(ker5), .col_o(col5), .row_o(row5),
    .valid_o(vo5), .frame_done_o(fd5), .busy_o(busy5)
`ifdef DOWNSAMPLE_WINDOW_CTRL_ERR_EN
    , .err_o(err5)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] tag(input int r, input int c);
    return 16'(r * 16 + c);
  endfunction

  // Drive one cycle of input to the selected instance, just after the edge.
  task automatic drive(input int dut, input bit vld, input logic [15:0] px, input bit s);
    @(posedge clk);
    #1;
    pixel = px;
    sof   = s;
    v4    = (dut == 4) && vld;
    v5    = (dut == 5) && vld;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4, 1'b0, 16'h0000, 1'b0);
  endtask

  // Send pixel (r,c); if it completes a window, queue the expected result.
  task automatic send_px(input int dut, input int w, input int h,
                         input int r, input int c, input bit s);
    exp_t e;
    drive(dut, 1'b1, tag(r, c), s);
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      e.win[0][0] = tag(r - 1, c - 1);
      e.win[0][1] = tag(r - 1, c);
      e.win[1][0] = tag(r, c - 1);
      e.win[1][1] = tag(r, c);
      e.col       = 16'(c / 2);
      e.row       = 16'(r / 2);
      e.done      = ((c / 2) == (w / 2 - 1)) && ((r / 2) == (h / 2 - 1));
      e.cyc       = cyc + 1;
      if (dut == 4) q4.push_back(e);
      else          q5.push_back(e);
    end
  endtask

  task automatic send_frame(input int dut, input int w, input int h, input bit gaps);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        send_px(dut, w, h, r, c, (r == 0) && (c == 0));
        if (gaps) drive(dut, 1'b0, 16'hdead, 1'b0);
      end
    end
  endtask

  task automatic cmp(input string tg, input exp_t e, input win_t w,
                     input logic [15:0] c, input logic [15:0] r, input logic d);
    check({tg, "_window"},  64'(w), 64'(e.win));
    check({tg, "_col_row"}, 64'({c, r}), 64'({e.col, e.row}));
    check({tg, "_done"},    64'(d), 64'(e.done));
    check({tg, "_latency"}, 64'(cyc), 64'(e.cyc));
  endtask

  // Monitor for the 4x4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (vo4) begin
      if (q4.size() == 0) check("dut4_unexpected_valid", 64'(1), 64'(0));
      else begin
        e = q4.pop_front();
        cmp("dut4", e, win4, col4, row4, fd4);
      end
    end
    if (fd4 && !vo4) check("dut4_done_without_valid", 64'(fd4), 64'(0));
  end

  // Monitor for the 5x5 instance.
  always @(negedge clk) begin
    exp_t e;
    if (vo5) begin
      if (q5.size() == 0) check("dut5_unexpected_valid", 64'(1), 64'(0));
      else begin
        e = q5.pop_front();
        cmp("dut5", e, win5, col5, row5, fd5);
      end
    end
    if (fd5 && !vo5) check("dut5_done_without_valid", 64'(fd5), 64'(0));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_window4", 64'(win4), 64'(0));
    check("rst_col_row4", 64'({col4, row4}), 64'(0));
    check("rst_strobes4", 64'({vo4, fd4, busy4}), 64'(0));
    check("rst_strobes5", 64'({vo5, fd5, busy5}), 64'(0));
    check("rst_kernel4", 64'(ker4), {4{16'h3400}});
    check("rst_kernel5", 64'(ker5), {4{16'h3400}});
`ifdef DOWNSAMPLE_WINDOW_CTRL_ERR_EN
    check("rst_err4", 64'(err4), 64'(0));
`endif
    rst_i = 1'b1;

    // Basic 4x4 frame, continuous valid.
    send_frame(4, 4, 4, 1'b0);
    check("basic_busy_before_last", 64'(busy4), 64'(1));
    idle(1);
    check("basic_busy_after_last", 64'(busy4), 64'(0));
    idle(3);
    check("basic_drained", 64'(q4.size()), 64'(0));

    // Same frame with valid toggling every cycle.
    send_frame(4, 4, 4, 1'b1);
    idle(3);
    check("gaps_drained", 64'(q4.size()), 64'(0));
    check("gaps_busy", 64'(busy4), 64'(0));

    // 5x5: last column and last line consumed, never emitted.
    send_frame(5, 5, 5, 1'b0);
    check("odd_busy_in_drain", 64'(busy5), 64'(1));
    idle(1);
    check("odd_busy_after_25", 64'(busy5), 64'(0));
    idle(3);
    check("odd_drained", 64'(q5.size()), 64'(0));

`ifdef DOWNSAMPLE_WINDOW_CTRL_ERR_EN
    check("err_clean_before_abort", 64'(err4), 64'(0));
`endif

    // Abort: restart with sof_i on the sixth pixel (row 1, col 1).
    for (int i = 0; i < 5; i++) send_px(4, 4, 4, i / 4, i % 4, i == 0);
    send_frame(4, 4, 4, 1'b0);
    idle(3);
    check("abort_drained", 64'(q4.size()), 64'(0));
`ifdef DOWNSAMPLE_WINDOW_CTRL_ERR_EN
    check("abort_err", 64'(err4), 64'(1));
`endif

    // Idle drop: valid pixels without sof_i are ignored.
    repeat (3) drive(4, 1'b1, 16'h0055, 1'b0);
    idle(3);
    check("drop_busy", 64'(busy4), 64'(0));
    check("drop_no_output", 64'(q4.size()), 64'(0));

    // Reset mid-frame while in the odd row.
    for (int i = 0; i < 7; i++) send_px(4, 4, 4, i / 4, i % 4, i == 0);
    idle(3);
    check("midframe_busy", 64'(busy4), 64'(1));
    @(posedge clk);
    #3;
    rst_i = 1'b0;
    #1;
    check("arst_window", 64'(win4), 64'(0));
    check("arst_col_row", 64'({col4, row4}), 64'(0));
    check("arst_strobes", 64'({vo4, fd4, busy4}), 64'(0));
`ifdef DOWNSAMPLE_WINDOW_CTRL_ERR_EN
    check("arst_err", 64'(err4), 64'(0));
`endif
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    send_frame(4, 4, 4, 1'b0);
    idle(3);
    check("post_reset_drained", 64'(q4.size()), 64'(0));
    check("post_reset_kernel", 64'(ker4), {4{16'h3400}});
    check("final_q5_empty", 64'(q5.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
